// File: rtl/regfile_access_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regctrl_pkg
// Desc     : Shared widths and request/data types for the register-file initiator.
// Revision : 1.0
// ============================================================================
package regctrl_pkg;

    localparam int DATA_W    = 8;
    localparam int ADDR_W    = 1;
    localparam int RSP_DEPTH = 4;

    typedef logic [DATA_W-1:0] data_t;
    typedef logic [ADDR_W-1:0] addr_t;

    typedef struct packed {
        logic  write;
        addr_t addr;
        data_t wdata;
    } req_t;

endpackage
`default_nettype wire

// File: rtl/regfile_access_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl_if
// Desc     : Request, response and register-file port bundle for the initiator.
// Revision : 1.0
// ============================================================================
interface regfile_access_ctrl_if;
    import regctrl_pkg::*;

    logic  ReqValid;
    logic  ReqReady;
    logic  ReqWrite;
    addr_t ReqAddr;
    data_t ReqWData;

    logic  RspValid;
    logic  RspReady;
    data_t RspData;

    addr_t RfAddr;
    logic  RfWrite;
    data_t RfWriteData;
    data_t RfData;

    modport slave (
        input  ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady, RfData,
        output ReqReady, RspValid, RspData, RfAddr, RfWrite, RfWriteData
    );

    modport master (
        output ReqValid, ReqWrite, ReqAddr, ReqWData, RspReady, RfData,
        input  ReqReady, RspValid, RspData, RfAddr, RfWrite, RfWriteData
    );

endinterface
`default_nettype wire

// File: rtl/regfile_access_ctrl_rsp_fifo.sv
`default_nettype none
// ============================================================================
// Module   : regctrl_rsp_fifo
// Desc     : Synchronous response FIFO with occupancy count; empty head reads 0.
// Revision : 1.0
// ============================================================================
module regctrl_rsp_fifo
    import regctrl_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             Clock,
    input  logic             nReset,
    input  logic             push_i,
    input  data_t            push_data_i,
    input  logic             pop_i,
    output data_t            pop_data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    data_t            mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             pop_en;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign empty_o    = (count_q == '0);
    assign full_o     = (count_q == CNT_W'(DEPTH));
    assign count_o    = count_q;
    assign pop_en     = pop_i && !empty_o;
    assign pop_data_o = empty_o ? '0 : mem_q[rd_ptr_q];

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge Clock) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (pop_en) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            case ({push_i, pop_en})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : regfile_access_ctrl
// Desc     : Pipelined initiator for the 2-entry sync register file with in-order,
//            credit-limited read responses. REGCTRL_WRITE_RSP_EN: writes also respond.
// Revision : 1.0
// ============================================================================
module regfile_access_ctrl
    import regctrl_pkg::*;
#(
    parameter int RSP_DEPTH = regctrl_pkg::RSP_DEPTH
) (
    input  logic                  Clock,
    input  logic                  nReset,
    regfile_access_ctrl_if.slave  bus
);

    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

`ifdef REGCTRL_WRITE_RSP_EN
    localparam logic c_WRITE_RSP = 1'b1;
`else
    localparam logic c_WRITE_RSP = 1'b0;
`endif

    req_t             req;
    logic             accept;
    logic             req_tag;
    logic             rsp_pop;
    logic             fifo_push;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W-1:0] pending;
    data_t            fifo_data;

    logic             rf_write_q;
    addr_t            rf_addr_q;
    data_t            rf_wdata_q;
    logic             s1_tag_q;
    logic             s2_tag_q;

    assign req = '{write: bus.ReqWrite, addr: bus.ReqAddr, wdata: bus.ReqWData};

    // Every op that will produce a response holds a credit from accept until pop.
    assign pending      = fifo_count + CNT_W'(s1_tag_q) + CNT_W'(s2_tag_q);
    assign bus.ReqReady = nReset && (pending < CNT_W'(RSP_DEPTH));
    assign accept       = bus.ReqValid && bus.ReqReady;
    assign req_tag      = !req.write || c_WRITE_RSP;
    assign rsp_pop      = bus.RspValid && bus.RspReady;
    assign fifo_push    = s2_tag_q && (!fifo_full || rsp_pop);

    assign bus.RfWrite     = rf_write_q;
    assign bus.RfAddr      = rf_addr_q;
    assign bus.RfWriteData = rf_wdata_q;
    assign bus.RspValid    = !fifo_empty;
    assign bus.RspData     = fifo_data;

    always_ff @(posedge Clock) begin
        if (!nReset) begin
            rf_write_q <= 1'b0;
            rf_addr_q  <= '0;
            rf_wdata_q <= '0;
            s1_tag_q   <= 1'b0;
            s2_tag_q   <= 1'b0;
        end else begin
            rf_write_q <= accept && req.write;
            s1_tag_q   <= accept && req_tag;
            s2_tag_q   <= s1_tag_q;
            if (accept) begin
                rf_addr_q  <= req.addr;
                rf_wdata_q <= req.wdata;
            end
        end
    end

    // RfData returned for the op in stage 2 is captured as that op's response.
    regctrl_rsp_fifo #(
        .DEPTH (RSP_DEPTH),
        .CNT_W (CNT_W)
    ) u_rsp_fifo (
        .Clock       (Clock),
        .nReset      (nReset),
        .push_i      (fifo_push),
        .push_data_i (bus.RfData),
        .pop_i       (rsp_pop),
        .pop_data_o  (fifo_data),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count)
    );

endmodule
`default_nettype wire

// File: tb/tb_regfile_access_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_access_ctrl
// Desc     : Scoreboard bench with a register-content model and a sync RF model.
// Revision : 1.0
// ============================================================================
module tb_regfile_access_ctrl;
    import regctrl_pkg::*;

    localparam int DEPTH = 4;

    typedef struct {
        data_t data;
        int    cyc;
    } exp_t;

    logic  clk    = 1'b0;
    logic  nReset = 1'b0;
    int    cyc          = 0;
    int    checks       = 0;
    int    errors       = 0;
    int    npops        = 0;
    int    last_pop_cyc = 0;
    int    rsp_mode     = 0;
    exp_t  sbq [$];
    data_t regs   [2] = '{default: '0};
    data_t rf_mem [2] = '{default: '0};
    data_t rf_q       = '0;
    logic  p_fire  = 1'b0;
    logic  p_write = 1'b0;
    addr_t p_addr  = '0;
    data_t p_wdata = '0;

    regfile_access_ctrl_if bus();

    regfile_access_ctrl #(.RSP_DEPTH(DEPTH)) dut (
        .Clock  (clk),
        .nReset (nReset),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Register file: read-before-write, Data valid the cycle after the op.
    always @(posedge clk) begin
        rf_q <= rf_mem[bus.RfAddr];
        if (bus.RfWrite) rf_mem[bus.RfAddr] <= bus.RfWriteData;
    end
    assign bus.RfData = rf_q;

    task automatic chk(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, got, exp);
        end
    endtask

    // Monitor: RF port follows accepts, credits, and in-order responses.
    always @(negedge clk) begin
        exp_t e;
        logic fire;
        chk("rf_write", int'(bus.RfWrite), int'(p_fire && p_write));
        if (p_fire) chk("rf_addr", int'(bus.RfAddr), int'(p_addr));
        if (p_fire && p_write) chk("rf_wdata", int'(bus.RfWriteData), int'(p_wdata));
        if (nReset) chk("req_ready_credit", int'(bus.ReqReady), int'(sbq.size() < DEPTH));
        else        chk("req_ready_reset", int'(bus.ReqReady), 0);
        if (bus.RspValid && bus.RspReady) begin
            npops++;
            last_pop_cyc = cyc;
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got 0x%0h required no response", bus.RspData);
            end else begin
                e = sbq.pop_front();
                chk("rsp_data", int'(bus.RspData), int'(e.data));
                chk("rsp_latency_min", int'((cyc - e.cyc) >= 3), 1);
            end
        end
        fire = bus.ReqValid && bus.ReqReady;
        if (fire) begin
            if (!bus.ReqWrite) begin
                sbq.push_back('{data: regs[bus.ReqAddr], cyc: cyc});
            end else begin
`ifdef REGCTRL_WRITE_RSP_EN
                sbq.push_back('{data: regs[bus.ReqAddr], cyc: cyc});
`endif
                regs[bus.ReqAddr] = bus.ReqWData;
            end
        end
        p_fire  = fire;
        p_write = bus.ReqWrite;
        p_addr  = bus.ReqAddr;
        p_wdata = bus.ReqWData;
        if (!nReset) sbq.delete();
    end

    initial begin
        bus.RspReady = 1'b1;
        forever begin
            @(posedge clk);
            #2;
            case (rsp_mode)
                0:       bus.RspReady = 1'b1;
                1:       bus.RspReady = 1'b0;
                default: bus.RspReady = ($urandom_range(0, 3) != 0);
            endcase
        end
    end

    task automatic send(input logic w, input addr_t a, input data_t d, output int acc);
        int n;
        n   = 0;
        acc = -1;
        bus.ReqValid = 1'b1;
        bus.ReqWrite = w;
        bus.ReqAddr  = a;
        bus.ReqWData = d;
        @(negedge clk);
        while (!bus.ReqReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (bus.ReqReady) begin
            acc = cyc;
        end else begin
            checks++;
            errors++;
            $display("FAIL req_accept_timeout: got ReqReady=0 required 1 within 100 cycles");
        end
        @(posedge clk);
        #1;
        bus.ReqValid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending responses required 0", sbq.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int c1, c2, c3, np, n;
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = '0;
        bus.ReqWData = '0;

        // Reset held with a request pending
        repeat (2) begin
            @(negedge clk);
            chk("t1_rsp_valid", int'(bus.RspValid), 0);
            chk("t1_rsp_data", int'(bus.RspData), 0);
            chk("t1_rf_write", int'(bus.RfWrite), 0);
            chk("t1_rf_addr", int'(bus.RfAddr), 0);
            chk("t1_req_ready", int'(bus.ReqReady), 0);
        end
        @(posedge clk);
        #1;
        nReset = 1'b1;
        @(negedge clk);
        chk("t1_ready_after_release", int'(bus.ReqReady), 1);
        @(posedge clk);
        #1;
        bus.ReqValid = 1'b0;
        drain();

        // Write then read the same register
        send(1'b1, 1'b1, 8'h5A, c1);
        send(1'b0, 1'b1, 8'h00, c1);
        drain();
        chk("t2_read_latency", last_pop_cyc - c1, 3);

        // Back-to-back reads
        send(1'b1, 1'b0, 8'h11, c1);
        send(1'b1, 1'b1, 8'h22, c1);
        drain();
        send(1'b0, 1'b0, 8'h00, c1);
        send(1'b0, 1'b1, 8'h00, c2);
        send(1'b0, 1'b0, 8'h00, c3);
        drain();
        chk("t3_accept_gap", c2 - c1, 1);
        chk("t3_back_to_back", c3 - c1, 2);
        chk("t3_rsp_consecutive", last_pop_cyc - c3, 3);

        // Response backpressure fills the credits
        rsp_mode = 1;
        np = npops;
        n  = 0;
        bus.ReqValid = 1'b1;
        bus.ReqWrite = 1'b0;
        bus.ReqAddr  = 1'b1;
        repeat (10) begin
            @(negedge clk);
            if (bus.ReqReady) n++;
            @(posedge clk);
            #1;
        end
        bus.ReqValid = 1'b0;
        chk("t4_accepted", n, DEPTH);
        @(negedge clk);
        chk("t4_ready_full", int'(bus.ReqReady), 0);
        @(posedge clk);
        #1;
        rsp_mode = 0;
        drain();
        chk("t4_pops", npops - np, DEPTH);

        // Reset with two responses buffered and two reads in flight
        rsp_mode = 1;
        send(1'b0, 1'b0, 8'h00, c1);
        send(1'b0, 1'b1, 8'h00, c1);
        idle(3);
        send(1'b0, 1'b0, 8'h00, c1);
        send(1'b0, 1'b1, 8'h00, c1);
        nReset = 1'b0;
        @(posedge clk);
        #1;
        nReset   = 1'b1;
        rsp_mode = 0;
        np = npops;
        repeat (5) begin
            @(negedge clk);
            chk("t5_rsp_valid", int'(bus.RspValid), 0);
            chk("t5_credits_full", int'(bus.ReqReady), 1);
        end
        @(posedge clk);
        #1;
        chk("t5_no_stale", npops - np, 0);

        // Write response behaviour, then read back
        send(1'b1, 1'b0, 8'h33, c1);
        drain();
        np = npops;
        send(1'b1, 1'b0, 8'h7F, c1);
        drain();
`ifdef REGCTRL_WRITE_RSP_EN
        chk("t6_write_rsp_count", npops - np, 1);
`else
        chk("t6_write_rsp_count", npops - np, 0);
`endif
        send(1'b0, 1'b0, 8'h00, c1);
        drain();

        // Randomised traffic with random response backpressure
        rsp_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send(logic'($urandom_range(0, 2) == 0), addr_t'($urandom_range(0, 1)),
                 data_t'($urandom), c1);
            if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 3)));
        end
        rsp_mode = 0;
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
